// File: rtl/sv32_table_walk_if.sv
// Sv32 walk handshake plus PTE read port.
// slave = walker side, master = translator/memory side.
interface sv32_table_walk_if;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [31:0] satp;
  logic [31:0] pte;
  logic        mem_valid;
  logic        mem_ready;
  logic [33:0] mem_addr;
  logic [31:0] mem_rdata;

  modport slave (
    input  valid, address, satp, mem_ready, mem_rdata,
    output ready, pte, mem_valid, mem_addr
  );

  modport master (
    output valid, address, satp, mem_ready, mem_rdata,
    input  ready, pte, mem_valid, mem_addr
  );
endinterface

// File: rtl/sv32_table_walk.sv
// Two-level Sv32 page-table walker; returns leaf PTE or zero on fault.
// Optional single-entry result cache: SV32_WALK_PTE_CACHE_EN.
module sv32_table_walk (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  sv32_table_walk_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, L1_READ, L0_READ, DONE
  } state_t;

  state_t      state;
  logic [19:0] vpn;

  logic        pv, pr, pw, px;
  logic        fault, leaf, hs;
  logic        fin;
  logic [31:0] res;
  logic [31:0] mega;
  logic [33:0] l1_addr, l0_addr;
  logic        hit;
  logic [31:0] hit_pte;
  logic        unused;

  assign pv = bus.mem_rdata[0];
  assign pr = bus.mem_rdata[1];
  assign pw = bus.mem_rdata[2];
  assign px = bus.mem_rdata[3];
  assign fault = !pv || (pw && !pr);
  assign leaf  = pr || px;
  assign hs    = bus.mem_valid && bus.mem_ready;

  // Megapage: low PPN comes from the VA.
  assign mega = {bus.mem_rdata[31:20], vpn[9:0],
                 bus.mem_rdata[9:0]};

  assign l1_addr = {bus.satp[21:0], 12'b0}
                 + {22'b0, bus.address[31:22], 2'b00};
  assign l0_addr = {bus.mem_rdata[31:10], 12'b0}
                 + {22'b0, vpn[9:0], 2'b00};

  always_comb begin
    fin = 1'b0;
    res = '0;
    if (hs) begin
      if (state == L1_READ) begin
        if (fault) begin
          fin = 1'b1;
        end else if (leaf) begin
          fin = 1'b1;
          res = (bus.mem_rdata[19:10] != 10'd0) ? '0 : mega;
        end
      end else if (state == L0_READ) begin
        fin = 1'b1;
        res = (fault || !leaf) ? '0 : bus.mem_rdata;
      end
    end
  end

`ifdef SV32_WALK_PTE_CACHE_EN
  logic        c_valid;
  logic [31:0] c_satp;
  logic [19:0] c_vpn;
  logic [31:0] c_pte;
  logic [31:0] req_satp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_valid  <= 1'b0;
      c_satp   <= '0;
      c_vpn    <= '0;
      c_pte    <= '0;
      req_satp <= '0;
    end else begin
      if (state == IDLE && bus.valid && !bus.ready)
        req_satp <= bus.satp;
      if (flush) begin
        c_valid <= 1'b0;
      end else if (fin && res != '0) begin
        c_valid <= 1'b1;
        c_satp  <= req_satp;
        c_vpn   <= vpn;
        c_pte   <= res;
      end
    end
  end

  assign hit = c_valid && !flush
            && bus.satp == c_satp
            && bus.address[31:12] == c_vpn;
  assign hit_pte = c_pte;
  assign unused  = ^bus.address[11:0];
`else
  assign hit     = 1'b0;
  assign hit_pte = '0;
  assign unused  = ^{flush, vpn[19:10],
                     bus.satp[30:22], bus.address[11:0]};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      vpn           <= '0;
      bus.ready     <= 1'b0;
      bus.pte       <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
    end else begin
      bus.ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.valid && !bus.ready) begin
            vpn <= bus.address[31:12];
            if (hit) begin
              state     <= DONE;
              bus.ready <= 1'b1;
              bus.pte   <= hit_pte;
            end else if (!bus.satp[31]) begin
              state     <= DONE;
              bus.ready <= 1'b1;
              bus.pte   <= '0;
            end else begin
              state         <= L1_READ;
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= l1_addr;
            end
          end
        end
        L1_READ, L0_READ: begin
          if (fin) begin
            state         <= DONE;
            bus.ready     <= 1'b1;
            bus.mem_valid <= 1'b0;
            bus.pte       <= res;
          end else if (hs) begin
            state        <= L0_READ;
            bus.mem_addr <= l0_addr;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sv32_table_walk.md
Name: sv32_table_walk

Overview:
- Responder side of the Sv32 walk handshake used by the data/instruction translators.
- Accepts a walk request (virtual address plus satp) and performs the two-level Sv32 page-table walk over a simple 34-bit physical memory read port.
- Returns the leaf PTE with its PPN already adjusted for megapages, or an all-zero PTE on a walk fault.
- An all-zero PTE has R=W=X=U=0, so the requesting translator raises a page fault without any extra signalling.

Parameters:
- none (Sv32 geometry fixed: 4 KiB pages, 4-byte PTEs, 2 levels)

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- valid  in  1  walk request (driven by translator walk_valid)
- ready  out  1  one-cycle completion pulse (to translator walk_ready)
- address  in  32  virtual address to walk
- satp  in  32  satp CSR; MODE=bit31, root PPN=bits[21:0]
- pte  out  32  resulting leaf PTE; 0 = fault
- mem_valid  out  1  PTE read request
- mem_ready  in  1  read data valid / request accepted
- mem_addr  out  34  physical PTE address
- mem_rdata  in  32  PTE read data
- flush  in  1  sfence.vma invalidate (used only with the optional feature)

Behaviour:
- Reset: asynchronous, active-low. ready=0, mem_valid=0, mem_addr=0, pte=0, state=IDLE, cache invalidated. Asserting reset mid-walk aborts the walk at once: mem_valid drops with no completion.
- States: IDLE, L1_READ, L0_READ, DONE.
- IDLE:
  - Accept when valid && !ready; latch address and satp. valid is not sampled again until the walk returns to IDLE, so dropping valid mid-walk has no effect.
  - satp[31]=0 (bare mode, protocol error): go to DONE with pte=0.
  - Otherwise mem_addr = {satp[21:0],12'b0} + {address[31:22],2'b00}, go to L1_READ.
- L1_READ:
  - mem_valid=1; mem_addr held stable until mem_ready.
  - mem_rdata is sampled only when mem_valid && mem_ready; zero-wait memory (mem_ready in the first cycle) is legal.
  - Fault → pte=0, DONE: V=0, or (W=1 && R=0).
  - Leaf (R|X): if PPN0 = rdata[19:10] ≠ 0, misaligned megapage → pte=0. Otherwise pte = rdata with bits[19:10] replaced by address[21:12]. Go to DONE.
  - Pointer (R=X=0): mem_addr = {rdata[31:10],12'b0} + {address[21:12],2'b00}, go to L0_READ.
- L0_READ:
  - Same handshake as L1_READ.
  - Fault → pte=0: V=0, (W && !R), or non-leaf (R=X=0).
  - Otherwise pte = rdata. Go to DONE.
- DONE: ready=1 for exactly one cycle, then IDLE.
- pte is registered and held stable from the ready pulse until the next accepted request; the translator samples it the cycle after ready.
- Latency from the accept cycle, zero-wait memory: megapage leaf → ready in cycle 2; 4 KiB leaf → cycle 3. Each memory wait cycle adds 1.
- Accessed/dirty bits are passed through unmodified; the walker performs no A/D checks and no PTE writes.
- Address arithmetic: 34-bit unsigned; no carry beyond bit 33.

Optional Feature:
- Macro: SV32_WALK_PTE_CACHE_EN.
- With the macro: a single-entry cache holds {valid, satp, address[31:12], pte}.
  - Fill: on every successful (non-zero pte) walk completion.
  - Hit: in IDLE, when valid && satp matches && VPN matches → go straight to DONE (ready in cycle 1), no mem_valid, pte from cache.
  - flush=1 invalidates the entry in the same cycle. Flush takes priority over a same-cycle fill.
  - Faulting walks are never cached.
- Without the macro: flush is ignored and every request walks memory.

Test Plan:
- 4 KiB walk: satp=0x80000080, address=0x00401234; L1 read at 0x80004 returns 0x00020401; L0 read at 0x81004 returns 0x000240CF → pte=0x000240CF, ready in cycle 3 with zero-wait memory.
- Megapage: same address; L1 returns 0x001000CF → exactly one memory read, pte=0x001004CF.
- Misaligned megapage: L1 returns 0x001004CF → pte=0x00000000, no L0 access.
- Invalid/reserved PTEs:
  - L1 returns 0x00000000 → pte=0 after one read.
  - L0 returns 0x00024005 (W-only) → pte=0.
  - L0 returns 0x00024001 (non-leaf) → pte=0.
- Wait states and reset: mem_ready held low 3 cycles in L1_READ → mem_addr stable, ready in cycle 6. Reset asserted in L0_READ → mem_valid=0 and pte=0 immediately; no ready pulse.
- With SV32_WALK_PTE_CACHE_EN: repeat the first test → ready in cycle 1 with no mem_valid. Pulse flush, repeat → full walk again with 2 reads.
